// File: rtl/cprv_wb_arbiter.sv
// Writeback arbiter: merges ALU and LSU results onto one register-file write port (CPRV_WB_BYPASS_EN adds rsN_fwd_hit).
// Latency 1 cycle select-to-rd_*; LSU backpressured via lsu_ready when its buffer is full, ALU only via a one-cycle alu_stall.
module cprv_wb_arbiter #(
    parameter int DATA_WIDTH     = 64,
    parameter int REGADDR_WIDTH  = 5,
    parameter int LSU_FIFO_DEPTH = 2,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    input  logic [REGADDR_WIDTH-1:0] alu_rd_addr,
    input  logic [DATA_WIDTH-1:0]    alu_rd_data,
    output logic                     alu_stall,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [REGADDR_WIDTH-1:0] lsu_rd_addr,
    input  logic [DATA_WIDTH-1:0]    lsu_rd_data,
    output logic                     rd_en,
    output logic [REGADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data,
    input  logic [REGADDR_WIDTH-1:0] rs1_addr,
    input  logic [REGADDR_WIDTH-1:0] rs2_addr,
    output logic                     rs1_fwd_hit,
    output logic                     rs2_fwd_hit
);

    localparam int PTR_W = (LSU_FIFO_DEPTH > 1) ? $clog2(LSU_FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [REGADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]    data;
    } wb_t;

    wb_t                mem [LSU_FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [STV_W-1:0]   starve_cnt;
    logic [STV_W-1:0]   starve_nxt;
    logic               stall_nxt;

    logic               fifo_empty;
    logic               fifo_full;
    logic               alu_take;
    logic               lsu_fire;
    logic               lsu_keep;
    logic               sel_fifo;
    logic               sel_alu;
    logic               sel_lsu;
    logic               enq;
    logic               wr_vld;
    wb_t                wr_dat;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(LSU_FIFO_DEPTH));
    assign lsu_ready  = !fifo_full && !rst;
    assign lsu_fire   = lsu_valid && lsu_ready;
    // Register-0 results complete their handshake but are dropped here.
    assign lsu_keep   = lsu_fire && (lsu_rd_addr != '0);
    assign alu_take   = alu_valid && !alu_stall && (alu_rd_addr != '0);

    always_comb begin
        sel_fifo = 1'b0;
        sel_alu  = 1'b0;
        sel_lsu  = 1'b0;
        if (alu_stall) begin
            sel_fifo = !fifo_empty;
        end else if (alu_take) begin
            sel_alu = 1'b1;
        end else if (!fifo_empty) begin
            sel_fifo = 1'b1;
        end else if (lsu_keep) begin
            sel_lsu = 1'b1;
        end
    end

    assign enq    = lsu_keep && !sel_lsu;
    assign wr_vld = sel_fifo || sel_alu || sel_lsu;

    always_comb begin
        wr_dat = '{addr: lsu_rd_addr, data: lsu_rd_data};
        if (sel_fifo) begin
            wr_dat = mem[rd_ptr];
        end else if (sel_alu) begin
            wr_dat = '{addr: alu_rd_addr, data: alu_rd_data};
        end
    end

    // Only ALU wins over a waiting head age the starve counter.
    always_comb begin
        starve_nxt = starve_cnt;
        stall_nxt  = 1'b0;
        if (sel_fifo || fifo_empty) begin
            starve_nxt = '0;
        end else if (sel_alu) begin
            if (starve_cnt == STV_W'(STARVE_LIMIT - 1)) begin
                stall_nxt  = 1'b1;
                starve_nxt = '0;
            end else begin
                starve_nxt = starve_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= '{addr: lsu_rd_addr, data: lsu_rd_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            alu_stall  <= 1'b0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            rd_data    <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (sel_fifo) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({enq, sel_fifo})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            starve_cnt <= starve_nxt;
            alu_stall  <= stall_nxt;
            rd_en      <= wr_vld;
            if (wr_vld) begin
                rd_addr <= wr_dat.addr;
                rd_data <= wr_dat.data;
            end
        end
    end

`ifdef CPRV_WB_BYPASS_EN
    assign rs1_fwd_hit = rd_en && (rd_addr == rs1_addr) && (rd_addr != '0);
    assign rs2_fwd_hit = rd_en && (rd_addr == rs2_addr) && (rd_addr != '0);
`else
    logic unused_rs;
    assign unused_rs   = ^{rs1_addr, rs2_addr};
    assign rs1_fwd_hit = 1'b0;
    assign rs2_fwd_hit = 1'b0;
`endif

endmodule

// File: tb/tb_cprv_wb_arbiter.sv
// Bench for cprv_wb_arbiter: vector table plus multi-cycle sequences, writes checked through an expected-write queue.
module tb_cprv_wb_arbiter;

`ifdef CPRV_WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd_addr;
    logic [63:0] alu_rd_data;
    logic        alu_stall;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd_addr;
    logic [63:0] lsu_rd_data;
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic [63:0] rd_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_fwd_hit;
    logic        rs2_fwd_hit;

    cprv_wb_arbiter #(
        .DATA_WIDTH(64), .REGADDR_WIDTH(5), .LSU_FIFO_DEPTH(2), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd_addr(alu_rd_addr), .alu_rd_data(alu_rd_data),
        .alu_stall(alu_stall),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
        .lsu_rd_addr(lsu_rd_addr), .lsu_rd_data(lsu_rd_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_fwd_hit(rs1_fwd_hit), .rs2_fwd_hit(rs2_fwd_hit)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  a;
        logic [63:0] d;
        int          at;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        alu_v;
        logic [4:0]  alu_a;
        logic [63:0] alu_d;
        logic        lsu_v;
        logic [4:0]  lsu_a;
        logic [63:0] lsu_d;
        logic        e0_v;
        logic [4:0]  e0_a;
        logic [63:0] e0_d;
        logic        e1_v;
        logic [4:0]  e1_a;
        logic [63:0] e1_d;
    } vec_t;

    task automatic check1(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input logic [4:0] a, input logic [63:0] d, input int dly);
        exp_t e;
        e.a  = a;
        e.d  = d;
        e.at = cyc + dly;
        sb.push_back(e);
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected writes never seen, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] aa, input logic [63:0] ad,
                         input logic lv, input logic [4:0] la, input logic [63:0] ld);
        alu_valid   = av;
        alu_rd_addr = aa;
        alu_rd_data = ad;
        lsu_valid   = lv;
        lsu_rd_addr = la;
        lsu_rd_data = ld;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
    endtask

    // Every observed write must match the head of the expected queue, including its cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rd_en === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL wb_unexpected: got write x%0d=%0h at cycle %0d, required no write",
                             rd_addr, rd_data, cyc);
                end else begin
                    e = sb.pop_front();
                    if (rd_addr !== e.a || rd_data !== e.d || cyc != e.at) begin
                        errors++;
                        $display("FAIL wb_write: got x%0d=%0h at cycle %0d, required x%0d=%0h at cycle %0d",
                                 rd_addr, rd_data, cyc, e.a, e.d, e.at);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    vec_t vecs [8];
    logic stall_a [7];
    logic rdy_a   [7];
    logic stall_b [12];
    int   p;
    logic fire;

    initial begin
        vecs[0] = '{1'b1, 5'd3,  64'h11, 1'b0, 5'd0,  64'h0,  1'b1, 5'd3,  64'h11, 1'b0, 5'd0, 64'h0};
        vecs[1] = '{1'b1, 5'd0,  64'h55, 1'b1, 5'd0,  64'h66, 1'b0, 5'd0,  64'h0,  1'b0, 5'd0, 64'h0};
        vecs[2] = '{1'b1, 5'd5,  64'hA,  1'b1, 5'd6,  64'hB,  1'b1, 5'd5,  64'hA,  1'b1, 5'd6, 64'hB};
        vecs[3] = '{1'b0, 5'd0,  64'h0,  1'b1, 5'd9,  64'h99, 1'b1, 5'd9,  64'h99, 1'b0, 5'd0, 64'h0};
        vecs[4] = '{1'b1, 5'd0,  64'h12, 1'b1, 5'd4,  64'h44, 1'b1, 5'd4,  64'h44, 1'b0, 5'd0, 64'h0};
        vecs[5] = '{1'b1, 5'd7,  64'h77, 1'b1, 5'd0,  64'h13, 1'b1, 5'd7,  64'h77, 1'b0, 5'd0, 64'h0};
        vecs[6] = '{1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd1, 64'h1,
                    1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd1, 64'h1};
        vecs[7] = '{1'b0, 5'd0,  64'h0,  1'b0, 5'd0,  64'h0,  1'b0, 5'd0,  64'h0,  1'b0, 5'd0, 64'h0};
        stall_a = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        rdy_a   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 12; i++) stall_b[i] = (i == 5 || i == 11);

        rst = 1'b1;
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        idle();
        repeat (2) @(negedge clk);
        check1("reset_rd_en", rd_en, 0);
        check1("reset_rd_addr", rd_addr, 0);
        check1("reset_rd_data", rd_data, 0);
        check1("reset_alu_stall", alu_stall, 0);
        check1("reset_lsu_ready", lsu_ready, 0);
        rst = 1'b0;
        #1;
        check1("release_lsu_ready", lsu_ready, 1);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check1("vec_lsu_ready", lsu_ready, 1);
            check1("vec_alu_stall", alu_stall, 0);
            drive(vecs[i].alu_v, vecs[i].alu_a, vecs[i].alu_d,
                  vecs[i].lsu_v, vecs[i].lsu_a, vecs[i].lsu_d);
            if (vecs[i].e0_v) push(vecs[i].e0_a, vecs[i].e0_d, 1);
            if (vecs[i].e1_v) push(vecs[i].e1_a, vecs[i].e1_d, 2);
            @(negedge clk);
            idle();
            repeat (3) @(negedge clk);
            check_drained("vec_drained");
        end

        // Full buffer: ALU every cycle, three LSU offers held until accepted.
        p = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check1("full_lsu_ready", lsu_ready, rdy_a[i]);
            check1("full_alu_stall", alu_stall, stall_a[i]);
            drive(!stall_a[i], 5'(10 + i), 64'(100 + i),
                  (p < 3), 5'(20 + p), 64'(32'hA0 + p));
            if (!stall_a[i]) push(5'(10 + i), 64'(100 + i), 1);
            if (i == 5) push(5'd20, 64'hA0, 1);
            if (i == 6) begin
                push(5'd21, 64'hA1, 2);
                push(5'd22, 64'hA2, 3);
            end
            #1;
            fire = lsu_valid && lsu_ready;
            if (fire) p++;
        end
        @(negedge clk);
        idle();
        check1("full_accepts", p, 3);
        repeat (4) @(negedge clk);
        check_drained("full_drained");

        // Starvation: ALU held valid throughout, even in stall cycles.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check1("starve_alu_stall", alu_stall, stall_b[i]);
            drive(1'b1, 5'(1 + i), 64'(200 + i),
                  (i == 0 || i == 6), (i == 0) ? 5'd30 : 5'd29, (i == 0) ? 64'hC0 : 64'hC1);
            if (!stall_b[i]) push(5'(1 + i), 64'(200 + i), 1);
            if (i == 5) push(5'd30, 64'hC0, 1);
            if (i == 11) push(5'd29, 64'hC1, 1);
        end
        @(negedge clk);
        check1("starve_stall_single", alu_stall, 0);
        idle();
        repeat (3) @(negedge clk);
        check_drained("starve_drained");

        // Reset with two entries buffered.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 2) check1("rst_pre_full", lsu_ready, 0);
            drive(1'b1, (i == 2) ? 5'd7 : 5'(2 + i), 64'(32'h300 + i),
                  (i < 2), 5'(17 + i), 64'(32'hD0 + i));
            push((i == 2) ? 5'd7 : 5'(2 + i), 64'(32'h300 + i), 1);
        end
        rs1_addr = 5'd7;
        rs2_addr = 5'd3;
        @(posedge clk);
        #2;
        idle();
        check1("rst_pre_rd_en", rd_en, 1);
        check1("rst_pre_rd_addr", rd_addr, 7);
        check1("bypass_rs1_hit", rs1_fwd_hit, BYP);
        check1("bypass_rs2_miss", rs2_fwd_hit, 0);
        rst = 1'b1;
        #1;
        check1("rst_async_rd_en", rd_en, 0);
        check1("rst_async_rd_addr", rd_addr, 0);
        check1("rst_async_lsu_ready", lsu_ready, 0);
        check1("rst_async_rs1_hit", rs1_fwd_hit, 0);
        @(negedge clk);
        check1("rst_hold_lsu_ready", lsu_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check1("rst_release_lsu_ready", lsu_ready, 1);
        repeat (5) @(negedge clk);
        check1("rst_no_stale_en", rd_en, 0);
        check_drained("final_drained");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
